// File: rtl/norm_shift.sv
// Multi-cycle normalizer: binary-search count-leading-zeros / redundant-sign-bits
// plus the normalized word, one search step per cycle behind a valid/ready handshake.
module norm_shift #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             AL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] dout,
  output logic [5:0]       shamt,
  output logic             zero
);

  localparam logic [2:0] KFirst = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       k_q, k_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [5:0]       c_q, c_d;
  logic             al_q, al_d;
  logic             zflag_q, zflag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [5:0]       shamt_q, shamt_d;
  logic             zero_q, zero_d;

  logic             accept;
  logic             hit;
  logic [5:0]       n;
  logic [WIDTH-1:0] w_step;
  logic [5:0]       c_step;

  assign in_ready = !rst && !flush &&
                    ((state_q == StIdle) || ((state_q == StDone) && out_ready));
  assign accept   = in_valid && in_ready;

  // One search step: test the top n bits (zero mode) or top n+1 bits (sign mode).
  always_comb begin
    hit = 1'b0;
    case (k_q)
      3'd4:    hit = al_q ? ((&w_q[31:15]) || !(|w_q[31:15])) : !(|w_q[31:16]);
      3'd3:    hit = al_q ? ((&w_q[31:23]) || !(|w_q[31:23])) : !(|w_q[31:24]);
      3'd2:    hit = al_q ? ((&w_q[31:27]) || !(|w_q[31:27])) : !(|w_q[31:28]);
      3'd1:    hit = al_q ? ((&w_q[31:29]) || !(|w_q[31:29])) : !(|w_q[31:30]);
      3'd0:    hit = al_q ? (w_q[31] == w_q[30]) : !w_q[31];
      default: hit = 1'b0;
    endcase
  end

  assign n      = 6'd1 << k_q;
  assign w_step = hit ? (w_q << n) : w_q;
  assign c_step = hit ? (c_q + n) : c_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    w_d         = w_q;
    c_d         = c_q;
    al_d        = al_q;
    zflag_d     = zflag_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    shamt_d     = shamt_q;
    zero_d      = zero_q;

    if (flush) begin
      // Result registers keep their stale contents; only control is cleared.
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            w_d     = din;
            c_d     = 6'd0;
            al_d    = AL;
            zflag_d = (din == '0);
            k_d     = KFirst;
            state_d = StRun;
          end
        end
        StRun: begin
          w_d = w_step;
          c_d = c_step;
          if (k_q == 3'd0) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            dout_d      = w_step;
            zero_d      = zflag_q;
            // The search tops out at 31; 32 is only reachable for a zero operand.
            shamt_d     = (!al_q && zflag_q) ? 6'd32 : c_step;
          end else begin
            k_d = k_q - 3'd1;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = StIdle;
            if (accept) begin
              w_d     = din;
              c_d     = 6'd0;
              al_d    = AL;
              zflag_d = (din == '0);
              k_d     = KFirst;
              state_d = StRun;
            end
          end
        end
        default: begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      k_q         <= KFirst;
      w_q         <= '0;
      c_q         <= 6'd0;
      al_q        <= 1'b0;
      zflag_q     <= 1'b0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      shamt_q     <= 6'd0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      w_q         <= w_d;
      c_q         <= c_d;
      al_q        <= al_d;
      zflag_q     <= zflag_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      shamt_q     <= shamt_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign shamt     = shamt_q;
  assign zero      = zero_q;

endmodule

// File: doc/norm_shift.md
# norm_shift

Multi-cycle normalizer for the EX-stage ALU, the inverse of the barrel shifter. The barrel shifter takes a data word and a shift amount. This block takes a data word and produces two results: the left-shift amount that normalizes it, and the normalized word. It serves count-leading-zeros (unsigned mode) and count-leading-redundant-sign-bits (arithmetic mode) for the bit-manipulation path. It uses a 5-step binary search, one step per cycle, behind a valid/ready handshake so the pipeline can stall on it.

## Interface
- WIDTH, 32, data width; fixed at 32, since the step count (5) and the shamt width (6) are derived from it.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous abort of any in-flight operation (pipeline flush).
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- din  in  32  operand.
- AL  in  1  0 = count leading zeros; 1 = count leading redundant sign bits.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- dout  out  32  normalized word; equals din << shamt.
- shamt  out  6  normalizing shift amount, 0..32.
- zero  out  1  operand was all-zero (reported in both modes).

## Operation
- States: IDLE, RUN, DONE. A 3-bit step counter k runs 4 down to 0 in RUN.
- in_ready = !rst && !flush && (IDLE || (DONE && out_ready)).
- Accept = in_valid && in_ready. On accept:
  - working register w <= din, count c <= 0, mode latched, zflag <= (din == 0);
  - state <= RUN, k <= 4.
- RUN step k, with n = 2^k:
  - AL=0: if w[31:32-n] is all zero, then w <= w << n and c <= c + n.
  - AL=1: if w[31:31-n] (n+1 bits) is all equal, then w <= w << n and c <= c + n.
  - After step k=0: state <= DONE and the outputs are registered.
- Output registers:
  - dout <= w, zero <= zflag.
  - shamt <= (AL=0 && zflag) ? 32 : c.
  - AL=0 with a zero operand gives dout = 0, shamt = 32.
  - AL=1 with operand 0 or 0xFFFFFFFF gives shamt = 31.
- Result invariants:
  - AL=0, nonzero operand: dout[31] = 1.
  - AL=1, operand not 0/-1: dout[31] != dout[30].
  - Always: dout == din << shamt (modulo 2^32).
- DONE: out_valid = 1. dout, shamt and zero are held stable until out_valid && out_ready.
  - On the handshake edge: state <= IDLE, out_valid <= 0.
  - If an accept happens in the same cycle, state <= RUN instead.
- Reset values: state IDLE, out_valid 0, dout 0, shamt 0, zero 0, k 4, in_ready 0 while rst is high.
- Priority: rst > flush > handshake/accept.
  - flush forces state IDLE and out_valid 0 next cycle.
  - The result registers hold their old values under flush, and are don't-care while out_valid = 0.
  - A request presented during a flush cycle is not accepted.
- Width rules:
  - c is a 6-bit register with max 31 from the search; the value 32 comes only from the zero override.
  - Shifts are logical and zero-filled in both modes.

## Timing
- Latency: accept at edge E0; RUN steps at E1..E5; out_valid high in the cycle after E5. That is 5 cycles from acceptance to out_valid, independent of data.
- Throughput: one result per 6 cycles with a back-to-back handshake (DONE-to-RUN overlap). No accept is possible in RUN.
- All outputs except in_ready are registered. in_ready is combinational from state, out_ready, flush and rst.
- Backpressure: DONE persists indefinitely while out_ready = 0; outputs do not toggle.
- rst or flush in any RUN cycle: the operation is discarded and no out_valid pulse is produced. in_ready is 1 in the first cycle after rst/flush deasserts.

## Test plan
- Leading zeros: din=0x00010000, AL=0 -> shamt=15, dout=0x80000000, zero=0. out_valid asserts exactly 5 cycles after accept. Also din=0x80000000 -> shamt=0, dout=0x80000000.
- Zero and all-ones: din=0, AL=0 -> shamt=32, dout=0, zero=1. din=0, AL=1 -> shamt=31, dout=0, zero=1. din=0xFFFFFFFF, AL=1 -> shamt=31, dout=0x80000000, zero=0.
- Sign mode: din=0xFFFF8000, AL=1 -> shamt=16, dout=0x80000000. din=0x00000001, AL=1 -> shamt=30, dout=0x40000000.
- Backpressure/overlap: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0. Then drive out_ready=1 and in_valid=1 (din=0x0000FFFF, AL=0) in the same cycle -> new request accepted; next result shamt=16, dout=0xFFFF0000.
- Abort: flush in the 3rd RUN cycle -> no out_valid, in_ready=1 the next cycle, and a following request (din=0x00000100, AL=0) -> shamt=23. Repeat with rst -> all outputs at their reset values.
- Random: 10k vectors, mixed AL, random out_ready, occasional flush. Every result is checked against a clz/cls reference model, the invariant dout == din << shamt, and the exact 5-cycle latency.
